// File: rtl/score_packer.sv
// score_packer: collects NUM_CLASSES serial class scores into one packed
// vector for the argmax stage. Class 0 lands in the most significant slot.
// Optional frame-alignment checking on in_last is compiled in when the
// macro SCORE_PACKER_LAST_CHECK_EN is defined; otherwise in_last is ignored
// and err is tied low.
module score_packer #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CLASSES = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH*NUM_CLASSES-1:0] out_vec,
    output logic                              err
);

    localparam int CW = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CLASSES - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [CW-1:0]         idx;
    logic                  accept;
    logic                  rel;
    logic [DATA_WIDTH-1:0] slots [NUM_CLASSES];

    // In HOLD the only way to take a score is alongside the release, so
    // readiness follows the consumer; reset blocks intake outright.
    assign in_ready = !reset && ((state == FILL) || out_ready);
    assign accept   = in_valid && in_ready;
    assign rel      = out_valid && out_ready;

    // An accept in HOLD is the first score of the next frame.
    assign idx = (state == HOLD) ? '0 : count;

    // Slot k maps onto the packed vector with class 0 in the MSBs.
    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_pack
        assign out_vec[DATA_WIDTH*(NUM_CLASSES-k)-1 -: DATA_WIDTH] = slots[k];
    end

    // Frame collection, hold/release handshake and slot writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            count     <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                slots[k] <= '0;
            end
        end else begin
            if ((state == HOLD) && rel) begin
                state     <= FILL;
                out_valid <= 1'b0;
            end
            if (accept) begin
                slots[idx] <= in_data;
                if (idx == LAST_IDX) begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                    count     <= '0;
                end else begin
                    count <= idx + CW'(1);
                end
`ifdef SCORE_PACKER_LAST_CHECK_EN
                // Early last drops the partial frame; overrides the increment.
                if (in_last && (idx != LAST_IDX)) begin
                    count <= '0;
                end
`endif
            end
        end
    end

`ifdef SCORE_PACKER_LAST_CHECK_EN
    // Sticky alignment error: in_last disagrees with the slot count.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept && (in_last != (idx == LAST_IDX))) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = in_last;
    assign err         = 1'b0;
`endif

endmodule
